// File: rtl/cordic_if.sv
// Handshake and atan-table bundle between the folded CORDIC engine and its neighbours.
// The engine takes the slave view; the producer, consumer and atan table together form the master side.
interface cordic_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] angle;
    logic [4:0]  tan_idx;
    logic [31:0] tan_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] cos_out;
    logic [31:0] sin_out;
    logic        busy;

    modport master (
        output in_valid, angle, tan_val, out_ready,
        input  in_ready, tan_idx, out_valid, cos_out, sin_out, busy
    );

    modport slave (
        input  in_valid, angle, tan_val, out_ready,
        output in_ready, tan_idx, out_valid, cos_out, sin_out, busy
    );
endinterface

// File: rtl/cordic_iter_sequencer.sv
// Folded rotation-mode CORDIC: one shift-add stage reused ITER times per angle,
// with an external combinational atan table addressed by the iteration index.
//
//   state  | meaning
//   S_IDLE | waiting for an angle, in_ready high
//   S_RUN  | one micro-rotation per cycle, tan_idx = iteration count
//   S_DONE | result presented, held until out_ready
module cordic_iter_sequencer #(
    parameter int          ITER   = 16,
    parameter logic [31:0] X_INIT = 32'h26DD3B6A
) (
    input logic     clk,
    input logic     rst_n,
    cordic_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [31:0] cos_q, cos_d, sin_q, sin_d;
    logic signed [31:0] x_sh, y_sh, x_nx, y_nx, z_nx;
    logic               last_iter;

    assign x_sh      = x_q >>> cnt_q;
    assign y_sh      = y_q >>> cnt_q;
    assign last_iter = (cnt_q == 5'(ITER - 1));

    // z == 0 deliberately takes the negative-rotation branch
    always_comb begin
        if (z_q > 32'sd0) begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - $signed(bus.tan_val);
        end else begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + $signed(bus.tan_val);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = $signed(X_INIT);
                    y_d     = 32'sd0;
                    z_d     = $signed(bus.angle);
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x_d   = x_nx;
                y_d   = y_nx;
                z_d   = z_nx;
                cnt_d = cnt_q + 5'd1;
                if (last_iter) begin
                    cos_d   = x_nx;
                    sin_d   = y_nx;
                    cnt_d   = 5'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            x_q     <= 32'sd0;
            y_q     <= 32'sd0;
            z_q     <= 32'sd0;
            cos_q   <= 32'sd0;
            sin_q   <= 32'sd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.tan_idx   = (state_q == S_RUN) ? cnt_q : 5'd0;
    assign bus.cos_out   = cos_q;
    assign bus.sin_out   = sin_q;
endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Directed bench for the folded CORDIC sequencer: a transaction-level model
// predicts handshake, table index and results; literal sin/cos values pin the model.
module tb_cordic_iter_sequencer;
    localparam int          ITER   = 16;
    localparam logic [31:0] X_INIT = 32'h26DD3B6A;
    localparam int          TOL    = 32768;

    logic clk;
    logic rst_n;
    cordic_if bus ();

    cordic_iter_sequencer #(.ITER(ITER), .X_INIT(X_INIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] rom [32];
    assign bus.tan_val = rom[bus.tan_idx];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_near(input string nm, input logic [31:0] act, input logic [31:0] exp);
        logic signed [31:0] d;
        d = $signed(act - exp);
        total++;
        if (d > TOL || d < -TOL) begin
            bad++;
            $display("FAIL %s: got %h expected %h +/- %0d at %0t", nm, act, exp, TOL, $time);
        end
    endtask

    // Straight rotation-mode CORDIC over the whole angle, no notion of cycles
    task automatic cordic_ref(input logic [31:0] a, output logic [31:0] c, output logic [31:0] s);
        logic signed [31:0] x, y, z, xn;
        x = $signed(X_INIT);
        y = 0;
        z = $signed(a);
        for (int i = 0; i < ITER; i++) begin
            if (z > 0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - $signed(rom[i]);
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + $signed(rom[i]);
            end
            x = xn;
        end
        c = x;
        s = y;
    endtask

    // Transaction model: phase 0 idle, 1 rotating (m_idx = iteration), 2 result held
    int          m_phase;
    int          m_idx;
    logic [31:0] m_cos, m_sin, m_nc, m_ns;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_idx   = 0;
            m_cos   = 0;
            m_sin   = 0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    cordic_ref(bus.angle, m_nc, m_ns);
                    m_idx   = 0;
                    m_phase = 1;
                end
                1: if (m_idx == ITER - 1) begin
                    m_cos   = m_nc;
                    m_sin   = m_ns;
                    m_idx   = 0;
                    m_phase = 2;
                end else begin
                    m_idx++;
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
            chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("tan_idx", 32'(bus.tan_idx), (m_phase == 1) ? 32'(m_idx) : 32'd0);
            chk("cos_out", bus.cos_out, m_cos);
            chk("sin_out", bus.sin_out, m_sin);
        end
    end

    task automatic run_op(input logic [31:0] a, input bit chk_first,
                          output logic [31:0] c, output logic [31:0] s, output int lat);
        bit seen;
        seen = 0;
        lat  = 0;
        c    = 0;
        s    = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.angle    = a;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.angle    = 32'h5A5A5A5A;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            if (n == 1 && chk_first) begin
                #1 chk("first_iter_neg_branch_y", dut.y_q, -X_INIT);
            end
            @(negedge clk);
            if (bus.out_valid) begin
                lat  = n;
                c    = bus.cos_out;
                s    = bus.sin_out;
                seen = 1;
                break;
            end
        end
        if (!seen) chk("result_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rc, rs, hc, hs;
    int          lat;
    bit          hit;

    initial begin
        for (int i = 0; i < 32; i++)
            rom[i] = 32'($rtoi($atan(2.0 ** (-i)) * 1073741824.0 + 0.5));

        cordic_ref(32'h2182A470, rc, rs);
        chk_near("model_pi6_cos", rc, 32'h376CF5D1);
        chk_near("model_pi6_sin", rs, 32'h20000000);

        bus.in_valid  = 1'b0;
        bus.angle     = 32'd0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_cos", bus.cos_out, 32'd0);
        chk("rst_sin", bus.sin_out, 32'd0);
        chk("rst_tan_idx", 32'(bus.tan_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        run_op(32'h00000000, 1'b0, rc, rs, lat);
        chk("lat_zero", 32'(lat), 32'(ITER));
        chk_near("zero_cos", rc, 32'h40000000);
        chk_near("zero_sin", rs, 32'h00000000);

        run_op(32'h2182A470, 1'b0, rc, rs, lat);
        chk("lat_pi6", 32'(lat), 32'(ITER));
        chk_near("pi6_cos", rc, 32'h376CF5D1);
        chk_near("pi6_sin", rs, 32'h20000000);

        run_op(32'hCDBC0957, 1'b1, rc, rs, lat);
        chk_near("mpi4_cos", rc, 32'h2D413CCD);
        chk_near("mpi4_sin", rs, 32'hD2BEC333);

        // Backpressure: result held while a new operand waits
        bus.out_ready = 1'b0;
        run_op(32'h2182A470, 1'b0, hc, hs, lat);
        bus.in_valid = 1'b1;
        bus.angle    = 32'hCDBC0957;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_cos_hold", bus.cos_out, hc);
            chk("bp_sin_hold", bus.sin_out, hs);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_handoff_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_handoff_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_accept_busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        hit = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                hit = 1;
                break;
            end
        end
        chk("bp_second_done", 32'(hit), 32'd1);
        chk_near("bp_second_cos", bus.cos_out, 32'h2D413CCD);
        chk_near("bp_second_sin", bus.sin_out, 32'hD2BEC333);
        @(negedge clk);

        // Reset in the middle of a rotation
        bus.in_valid = 1'b1;
        bus.angle    = 32'h2182A470;
        @(negedge clk);
        bus.in_valid = 1'b0;
        hit = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.tan_idx == 5'd7) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_reach_idx7", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_tan_idx", 32'(bus.tan_idx), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_cos", bus.cos_out, 32'd0);
        chk("mid_rst_sin", bus.sin_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hit = 0;
        for (int n = 0; n < ITER + 6; n++) begin
            @(negedge clk);
            if (bus.out_valid) hit = 1;
        end
        chk("mid_no_stray_valid", 32'(hit), 32'd0);
        chk("mid_idle_ready", 32'(bus.in_ready), 32'd1);

        run_op(32'h2182A470, 1'b0, rc, rs, lat);
        chk("post_rst_lat", 32'(lat), 32'(ITER));
        chk_near("post_rst_cos", rc, 32'h376CF5D1);
        chk_near("post_rst_sin", rs, 32'h20000000);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
